// File: rtl/hs_axi_arbiter.sv
// rtl/hs_axi_arbiter.sv - round-robin arbiter of handshake requesters onto one AXI4-Lite master
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   hs_read_i / hs_write_i        per-port requests, held until that port's hs_ready_o pulse
//   hs_addr_i / hs_data_i         per-port address and write data, port p at [p*W +: W]
//   hs_byte_select_i              per-port write byte enables
//   hs_ready_o / hs_err_o         one-cycle completion pulse and error flag for the granted port
//   hs_data_o                     shared read data, holds the last captured R beat
//   ar*/r*/aw*/w*/b*              AXI4-Lite master channels, one transaction in flight
module hs_axi_arbiter #(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic [NUM_PORTS-1:0]          hs_read_i,
  input  logic [NUM_PORTS-1:0]          hs_write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   hs_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   hs_data_i,
  input  logic [NUM_PORTS*STRB_W-1:0]   hs_byte_select_i,
  output logic [NUM_PORTS-1:0]          hs_ready_o,
  output logic [NUM_PORTS-1:0]          hs_err_o,
  output logic [DATA_W-1:0]             hs_data_o,

  output logic                          arvalid_o,
  input  logic                          aready_i,
  output logic [ADDR_W-1:0]             araddr_o,

  input  logic                          rvalid_i,
  output logic                          rready_o,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [1:0]                    rresp_i,

  output logic                          awvalid_o,
  input  logic                          awready_i,
  output logic [ADDR_W-1:0]             awaddr_o,

  output logic                          wvalid_o,
  input  logic                          wready_i,
  output logic [DATA_W-1:0]             wdata_o,
  output logic [STRB_W-1:0]             wstrb_o,

  input  logic                          bvalid_i,
  output logic                          bready_o,
  input  logic [1:0]                    bresp_i
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                err_q;

  logic [NUM_PORTS-1:0] req;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;
  logic                 found;

  // Round-robin search: the port just after the last winner has top
  // priority, wrapping, so a continuously requesting port can never be
  // granted twice while another port waits.
  always_comb begin
    req   = hs_read_i | hs_write_i;
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake outputs. AW and W are tracked separately
  // so either channel may accept first; the same-cycle ready is folded in
  // so both completing together still leaves WR_REQ after one cycle.
  always_comb begin
    state_d    = state_q;
    arvalid_o  = 1'b0;
    rready_o   = 1'b0;
    awvalid_o  = 1'b0;
    wvalid_o   = 1'b0;
    bready_o   = 1'b0;
    hs_ready_o = '0;
    hs_err_o   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          // a read wins when both requests are raised on the same port
          state_d = hs_read_i[pick] ? RD_ADDR : WR_REQ;
        end
      end
      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (aready_i) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          state_d = DONE;
        end
      end
      WR_REQ: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        if ((aw_done_q || awready_i) && (w_done_q || wready_i)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hs_ready_o[grant_q] = 1'b1;
        hs_err_o[grant_q]   = err_q;
        state_d             = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request payload is latched at grant so the AXI side stays stable even
  // if the requester's inputs wander; read data persists across writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q   <= pick;
            addr_q    <= hs_addr_i[int'(pick)*ADDR_W +: ADDR_W];
            wdata_q   <= hs_data_i[int'(pick)*DATA_W +: DATA_W];
            wstrb_q   <= hs_byte_select_i[int'(pick)*STRB_W +: STRB_W];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rdata_q <= rdata_i;
            err_q   <= (rresp_i != 2'b00);
          end
        end
        WR_REQ: begin
          if (awready_i) begin
            aw_done_q <= 1'b1;
          end
          if (wready_i) begin
            w_done_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            err_q <= (bresp_i != 2'b00);
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign hs_data_o = rdata_q;
  assign araddr_o  = addr_q;
  assign awaddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_hs_axi_arbiter.sv
// tb/tb_hs_axi_arbiter.sv - self-checking bench for hs_axi_arbiter
`timescale 1ns/1ps
module tb_hs_axi_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] KEY = 32'h5A5A_C3C3;

  logic               clk_i;
  logic               rst_ni;
  logic [NP-1:0]      hs_read_i;
  logic [NP-1:0]      hs_write_i;
  logic [NP*AW-1:0]   hs_addr_i;
  logic [NP*DW-1:0]   hs_data_i;
  logic [NP*SW-1:0]   hs_byte_select_i;
  logic [NP-1:0]      hs_ready_o;
  logic [NP-1:0]      hs_err_o;
  logic [DW-1:0]      hs_data_o;
  logic               arvalid_o, aready_i;
  logic [AW-1:0]      araddr_o;
  logic               rvalid_i, rready_o;
  logic [DW-1:0]      rdata_i;
  logic [1:0]         rresp_i;
  logic               awvalid_o, awready_i;
  logic [AW-1:0]      awaddr_o;
  logic               wvalid_o, wready_i;
  logic [DW-1:0]      wdata_o;
  logic [SW-1:0]      wstrb_o;
  logic               bvalid_i, bready_o;
  logic [1:0]         bresp_i;

  hs_axi_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hs_read_i(hs_read_i), .hs_write_i(hs_write_i), .hs_addr_i(hs_addr_i),
    .hs_data_i(hs_data_i), .hs_byte_select_i(hs_byte_select_i),
    .hs_ready_o(hs_ready_o), .hs_err_o(hs_err_o), .hs_data_o(hs_data_o),
    .arvalid_o(arvalid_o), .aready_i(aready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         port;
    logic       err;
    logic       multi;
    logic [DW-1:0] data;
    int         cyc;
  } comp_t;
  comp_t comp_q[$];

  // slave behaviour and observation log
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp, s_bresp;
  logic          rd_from_addr;
  int cyc, n_ar, n_aw, n_w, awv_cyc, wv_cyc, first_v, stray_err;
  logic [AW-1:0] last_araddr, last_awaddr;
  logic [DW-1:0] last_wdata;
  logic [SW-1:0] last_wstrb;

  // reference state: last winner and last read data seen by requesters
  int            m_last;
  logic [DW-1:0] last_rd;

  function automatic int rr_pick(int last, logic [NP-1:0] mask);
    int idx;
    for (int i = 1; i <= NP; i++) begin
      idx = (last + i) % NP;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: sample at the falling edge, log completions, drop served
  // requests, then drive the slave's responses for the coming rising edge.
  task automatic step();
    comp_t c;
    @(negedge clk_i);
    cyc++;
    if (first_v < 0 && (arvalid_o || awvalid_o || wvalid_o)) first_v = cyc;
    if (awvalid_o) awv_cyc++;
    if (wvalid_o) wv_cyc++;
    if ((hs_err_o & ~hs_ready_o) != '0) stray_err++;
    if (hs_ready_o != '0) begin
      c.port = -1;
      c.multi = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (hs_ready_o[p]) begin
          if (c.port < 0) c.port = p;
          else c.multi = 1'b1;
        end
      end
      c.err = |(hs_err_o & hs_ready_o);
      c.data = hs_data_o;
      c.cyc = cyc;
      comp_q.push_back(c);
      hs_read_i = hs_read_i & ~hs_ready_o;
      hs_write_i = hs_write_i & ~hs_ready_o;
    end
    if (arvalid_o && ar_cnt >= ar_dly) begin
      aready_i = 1'b1; n_ar++; last_araddr = araddr_o; ar_cnt = 0;
    end else begin
      aready_i = 1'b0; ar_cnt = arvalid_o ? ar_cnt + 1 : 0;
    end
    if (rready_o && r_cnt >= r_dly) begin
      rvalid_i = 1'b1; rresp_i = s_rresp; r_cnt = 0;
      rdata_i = rd_from_addr ? (last_araddr ^ KEY) : s_rdata;
    end else begin
      rvalid_i = 1'b0; rresp_i = 2'b11; rdata_i = ~s_rdata;
      r_cnt = rready_o ? r_cnt + 1 : 0;
    end
    if (awvalid_o && aw_cnt >= aw_dly) begin
      awready_i = 1'b1; n_aw++; last_awaddr = awaddr_o; aw_cnt = 0;
    end else begin
      awready_i = 1'b0; aw_cnt = awvalid_o ? aw_cnt + 1 : 0;
    end
    if (wvalid_o && w_cnt >= w_dly) begin
      wready_i = 1'b1; n_w++; last_wdata = wdata_o; last_wstrb = wstrb_o; w_cnt = 0;
    end else begin
      wready_i = 1'b0; w_cnt = wvalid_o ? w_cnt + 1 : 0;
    end
    if (bready_o && b_cnt >= b_dly) begin
      bvalid_i = 1'b1; bresp_i = s_bresp; b_cnt = 0;
    end else begin
      bvalid_i = 1'b0; bresp_i = 2'b11; b_cnt = bready_o ? b_cnt + 1 : 0;
    end
  endtask

  task automatic wait_comp(int bound);
    for (int k = 0; k < bound && comp_q.size() == 0; k++) step();
    chk("completion_seen", 64'(comp_q.size() > 0), 64'd1);
  endtask

  task automatic set_req(int p, int mode, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    hs_addr_i[p*AW +: AW] = a;
    hs_data_i[p*DW +: DW] = d;
    hs_byte_select_i[p*SW +: SW] = s;
    hs_read_i[p] = (mode != 1);
    hs_write_i[p] = (mode != 0);
  endtask

  task automatic set_slave(int ard, int rd, int awd, int wd, int bd, logic [1:0] rr, logic [1:0] br);
    ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd;
    s_rresp = rr; s_bresp = br;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ctl"}, 64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, hs_ready_o, hs_err_o}), 64'd0);
    chk({tag, "_hs_data"}, 64'(hs_data_o), 64'd0);
    chk({tag, "_addr"}, {araddr_o, awaddr_o}, 64'd0);
    chk({tag, "_wdata"}, 64'({wdata_o, wstrb_o}), 64'd0);
  endtask

  typedef struct {
    int            port;
    int            mode;     // 0 read, 1 write, 2 read+write
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            ar_d, r_d, aw_d, w_d, b_d;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int            exp_lat;
    logic          exp_err;
    int            exp_awv, exp_wv, exp_nar, exp_naw;
  } vec_t;
  vec_t vecs[7];

  initial begin
    comp_t c;
    int c0, nar0, naw0, nw0, total, just, expp, prev_cyc, d, nrd, nwr;
    int served[NP];
    int mode_a[NP];
    logic [AW-1:0] addr_a[NP];
    logic [DW-1:0] data_a[NP];
    logic [SW-1:0] strb_a[NP];
    logic [NP-1:0] pending, mask;
    logic [DW-1:0] exp_data;

    vecs[0] = '{0, 0, 32'h0000_1000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 1'b0, 0, 0, 1, 0};
    vecs[1] = '{1, 1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 0, 0, 3, 0, 0, 32'h0, 2'b00, 6, 1'b0, 4, 1, 0, 1};
    vecs[2] = '{2, 0, 32'h3000_0004, 32'h0, 4'h0, 1, 2, 0, 0, 0, 32'hCAFE_0001, 2'b10, 6, 1'b1, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 32'h0000_0100, 32'h0BAD_F00D, 4'b1100, 0, 0, 0, 2, 1, 32'h0, 2'b11, 6, 1'b1, 1, 3, 0, 1};
    vecs[4] = '{2, 1, 32'h0000_0044, 32'h5555_AAAA, 4'b1111, 0, 0, 2, 2, 0, 32'h0, 2'b00, 5, 1'b0, 3, 3, 0, 1};
    vecs[5] = '{1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 3, 0, 0, 0, 32'hA5A5_0F0F, 2'b00, 6, 1'b0, 0, 0, 1, 0};
    vecs[6] = '{0, 2, 32'h0000_0048, 32'h0000_0077, 4'b1111, 0, 0, 0, 0, 0, 32'h1357_9BDF, 2'b01, 3, 1'b1, 0, 0, 1, 0};

    rst_ni = 1'b0;
    hs_read_i = '0; hs_write_i = '0; hs_addr_i = '0; hs_data_i = '0; hs_byte_select_i = '0;
    aready_i = 0; rvalid_i = 0; rdata_i = '0; rresp_i = '0; awready_i = 0; wready_i = 0;
    bvalid_i = 0; bresp_i = '0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    s_rdata = '0; rd_from_addr = 1'b0;
    cyc = 0; n_ar = 0; n_aw = 0; n_w = 0; awv_cyc = 0; wv_cyc = 0; first_v = -1; stray_err = 0;
    last_araddr = '0; last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
    #3;
    check_reset_outputs("reset");
    repeat (2) step();
    rst_ni = 1'b1;
    m_last = NP - 1;
    last_rd = '0;
    step();

    // directed single transactions from IDLE
    for (int i = 0; i < 7; i++) begin
      set_slave(vecs[i].ar_d, vecs[i].r_d, vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].resp, vecs[i].resp);
      s_rdata = vecs[i].rdata; rd_from_addr = 1'b0;
      nar0 = n_ar; naw0 = n_aw; nw0 = n_w;
      awv_cyc = 0; wv_cyc = 0; first_v = -1; comp_q.delete();
      set_req(vecs[i].port, vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      c0 = cyc;
      wait_comp(60);
      if (comp_q.size() > 0) begin
        c = comp_q.pop_front();
        exp_data = (vecs[i].mode == 1) ? last_rd : vecs[i].rdata;
        chk($sformatf("v%0d_port", i), 64'(c.port), 64'(vecs[i].port));
        chk($sformatf("v%0d_multi", i), 64'(c.multi), 64'd0);
        chk($sformatf("v%0d_latency", i), 64'(c.cyc - c0), 64'(vecs[i].exp_lat));
        chk($sformatf("v%0d_err", i), 64'(c.err), 64'(vecs[i].exp_err));
        chk($sformatf("v%0d_data", i), 64'(c.data), 64'(exp_data));
        chk($sformatf("v%0d_first_valid", i), 64'(first_v - c0), 64'd1);
        chk($sformatf("v%0d_n_ar", i), 64'(n_ar - nar0), 64'(vecs[i].exp_nar));
        chk($sformatf("v%0d_n_aw", i), 64'(n_aw - naw0), 64'(vecs[i].exp_naw));
        chk($sformatf("v%0d_n_w", i), 64'(n_w - nw0), 64'(vecs[i].exp_naw));
        chk($sformatf("v%0d_awvalid_cycles", i), 64'(awv_cyc), 64'(vecs[i].exp_awv));
        chk($sformatf("v%0d_wvalid_cycles", i), 64'(wv_cyc), 64'(vecs[i].exp_wv));
        if (vecs[i].mode == 1) begin
          chk($sformatf("v%0d_awaddr", i), 64'(last_awaddr), 64'(vecs[i].addr));
          chk($sformatf("v%0d_wdata", i), 64'(last_wdata), 64'(vecs[i].wdata));
          chk($sformatf("v%0d_wstrb", i), 64'(last_wstrb), 64'(vecs[i].strb));
        end else begin
          chk($sformatf("v%0d_araddr", i), 64'(last_araddr), 64'(vecs[i].addr));
          last_rd = vecs[i].rdata;
        end
        m_last = vecs[i].port;
      end
      step();
      chk($sformatf("v%0d_ready_one_cycle", i), 64'(comp_q.size()), 64'd0);
    end

    // ports 0 and 1 request continuously, four reads each
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    rd_from_addr = 1'b1; comp_q.delete();
    for (int p = 0; p < NP; p++) served[p] = 0;
    set_req(0, 0, 32'h0000_0A00, '0, '0);
    set_req(1, 0, 32'h0000_0B10, '0, '0);
    c0 = cyc; total = 0; prev_cyc = -1;
    for (int k = 0; k < 100 && total < 8; k++) begin
      step();
      just = -1;
      if (comp_q.size() > 0) begin
        c = comp_q.pop_front();
        mask = '0;
        for (int p = 0; p < 2; p++) mask[p] = (served[p] < 4);
        expp = rr_pick(m_last, mask);
        chk("rr_port", 64'(c.port), 64'(expp));
        if (prev_cyc < 0) chk("rr_first_latency", 64'(c.cyc - c0), 64'd3);
        else chk("rr_gap", 64'(c.cyc - prev_cyc), 64'd4);
        chk("rr_data", 64'(c.data), 64'((expp == 0 ? 32'h0000_0A00 : 32'h0000_0B10) ^ KEY));
        prev_cyc = c.cyc; m_last = expp; served[expp]++; total++; just = expp;
      end
      for (int p = 0; p < 2; p++)
        if (!hs_read_i[p] && served[p] < 4 && p != just) hs_read_i[p] = 1'b1;
    end
    chk("rr_total", 64'(total), 64'd8);
    chk("rr_served0", 64'(served[0]), 64'd4);
    chk("rr_served1", 64'(served[1]), 64'd4);
    last_rd = (m_last == 0 ? 32'h0000_0A00 : 32'h0000_0B10) ^ KEY;
    repeat (2) step();

    // reset while waiting in RD_DATA
    set_slave(0, 6, 0, 0, 0, 2'b00, 2'b00);
    set_req(1, 0, 32'h0000_9000, '0, '0);
    for (int k = 0; k < 20 && !rready_o; k++) step();
    chk("reached_rd_data", 64'(rready_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("midreset");
    hs_read_i = '0; hs_write_i = '0;
    comp_q.delete(); nar0 = n_ar; naw0 = n_aw;
    repeat (3) step();
    rst_ni = 1'b1;
    m_last = NP - 1; last_rd = '0;
    repeat (3) step();
    chk("no_ready_after_reset", 64'(comp_q.size()), 64'd0);
    chk("no_axi_after_reset", 64'({n_ar - nar0, n_aw - naw0}), 64'd0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    set_req(0, 0, 32'h0000_0C00, '0, '0);
    set_req(1, 0, 32'h0000_0D00, '0, '0);
    c0 = cyc;
    wait_comp(40);
    if (comp_q.size() > 0) begin
      c = comp_q.pop_front();
      chk("post_reset_port", 64'(c.port), 64'(rr_pick(m_last, 3'b011)));
      chk("post_reset_latency", 64'(c.cyc - c0), 64'd3);
      chk("post_reset_data", 64'(c.data), 64'(32'h0000_0C00 ^ KEY));
      prev_cyc = c.cyc; m_last = 0;
    end
    wait_comp(40);
    if (comp_q.size() > 0) begin
      c = comp_q.pop_front();
      chk("post_reset_port2", 64'(c.port), 64'd1);
      chk("post_reset_gap", 64'(c.cyc - prev_cyc), 64'd4);
      m_last = 1; last_rd = 32'h0000_0D00 ^ KEY;
    end
    step();

    // randomized batches checked against the round-robin/latency model
    for (int b = 0; b < 30; b++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      rd_from_addr = 1'b1; comp_q.delete();
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      nrd = 0; nwr = 0;
      for (int p = 0; p < NP; p++) begin
        mode_a[p] = $urandom_range(0, 2);
        addr_a[p] = $urandom; data_a[p] = $urandom; strb_a[p] = SW'($urandom);
        if (mask[p]) begin
          set_req(p, mode_a[p], addr_a[p], data_a[p], strb_a[p]);
          if (mode_a[p] == 1) nwr++; else nrd++;
        end
      end
      nar0 = n_ar; naw0 = n_aw; nw0 = n_w;
      pending = mask; c0 = cyc; prev_cyc = -1;
      while (pending != '0) begin
        expp = rr_pick(m_last, pending);
        if (mode_a[expp] == 1) d = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        else d = ar_dly + r_dly;
        wait_comp(80);
        if (comp_q.size() == 0) break;
        c = comp_q.pop_front();
        chk("rnd_port", 64'(c.port), 64'(expp));
        chk("rnd_multi", 64'(c.multi), 64'd0);
        chk("rnd_cycle", 64'(c.cyc), 64'((prev_cyc < 0) ? c0 + 3 + d : prev_cyc + 4 + d));
        if (mode_a[expp] == 1) begin
          chk("rnd_werr", 64'(c.err), 64'(s_bresp != 2'b00));
          chk("rnd_data_held", 64'(c.data), 64'(last_rd));
          chk("rnd_awaddr", 64'(last_awaddr), 64'(addr_a[expp]));
          chk("rnd_wdata", 64'({last_wdata, last_wstrb}), 64'({data_a[expp], strb_a[expp]}));
        end else begin
          chk("rnd_rerr", 64'(c.err), 64'(s_rresp != 2'b00));
          chk("rnd_rdata", 64'(c.data), 64'(addr_a[expp] ^ KEY));
          chk("rnd_araddr", 64'(last_araddr), 64'(addr_a[expp]));
          last_rd = addr_a[expp] ^ KEY;
        end
        prev_cyc = c.cyc; m_last = expp; pending[expp] = 1'b0;
      end
      chk("rnd_n_ar", 64'(n_ar - nar0), 64'(nrd));
      chk("rnd_n_aw", 64'({n_aw - naw0, n_w - nw0}), {32'(nwr), 32'(nwr)});
      hs_read_i = '0; hs_write_i = '0;
      step();
    end

    chk("stray_err", 64'(stray_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
